// File: rtl/dclk_gen.sv
// Divided-clock generator: 50% duty dclk with per-period half-period latch and a tick on each rise.
// Optional runtime slow half-period register enabled by defining DCLK_GEN_LOAD_EN.
module dclk_gen #(
    parameter int unsigned W         = 8,
    parameter int unsigned SLOW_HALF = 4,
    parameter int unsigned FAST_HALF = 1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         act,
    input  logic         fast,
`ifdef DCLK_GEN_LOAD_EN
    input  logic         ld,
    input  logic [W-1:0] div_in,
`endif
    output logic         dclk,
    output logic         tick,
    output logic         busy
);

    localparam logic [W-1:0] SlowHalfW = W'(SLOW_HALF);
    localparam logic [W-1:0] FastHalfW = W'(FAST_HALF);
    localparam logic [W-1:0] One       = W'(1);

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StHi   = 3'b010,
        StLo   = 3'b100
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] hq_q, hq_d;
    logic         dclk_q, dclk_d;
    logic         tick_q, tick_d;
    logic         busy_q, busy_d;
    logic [W-1:0] slow_val;
    logic [W-1:0] h_raw;
    logic [W-1:0] h_new;

`ifdef DCLK_GEN_LOAD_EN
    logic [W-1:0] slow_q;

    // A load coinciding with a period start is seen from the next period on.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            slow_q <= SlowHalfW;
        end else if (ld) begin
            slow_q <= div_in;
        end
    end

    assign slow_val = slow_q;
`else
    assign slow_val = SlowHalfW;
`endif

    always_comb begin
        h_raw = fast ? FastHalfW : slow_val;
        h_new = (h_raw == '0) ? One : h_raw;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hq_d    = hq_q;
        tick_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (act) begin
                    state_d = StHi;
                    hq_d    = h_new;
                    cnt_d   = h_new - One;
                    tick_d  = 1'b1;
                end
            end
            StHi: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - One;
                end else begin
                    state_d = StLo;
                    cnt_d   = hq_q - One;
                end
            end
            StLo: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - One;
                end else if (act) begin
                    state_d = StHi;
                    hq_d    = h_new;
                    cnt_d   = h_new - One;
                    tick_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                hq_d    = One;
            end
        endcase
        dclk_d = (state_d == StHi);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hq_q    <= One;
            dclk_q  <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hq_q    <= hq_d;
            dclk_q  <= dclk_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign dclk = dclk_q;
    assign tick = tick_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dclk_gen.sv
// Directed bench for dclk_gen: captures per-cycle dclk/tick/busy and compares to hand-derived patterns.
// Load-register checks are compiled in when DCLK_GEN_LOAD_EN is defined.
module tb_dclk_gen;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_b;
    logic         act;
    logic         fast;
    logic         dclk;
    logic         tick;
    logic         busy;
`ifdef DCLK_GEN_LOAD_EN
    logic         ld;
    logic [W-1:0] div_in;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cap_d, cap_t, cap_b;

    dclk_gen #(
        .W         (W),
        .SLOW_HALF (4),
        .FAST_HALF (1)
    ) u_dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .act    (act),
        .fast   (fast),
`ifdef DCLK_GEN_LOAD_EN
        .ld     (ld),
        .div_in (div_in),
`endif
        .dclk   (dclk),
        .tick   (tick),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit i of each vector holds the value seen just after the (i+1)-th following rising edge.
    task automatic capture(input int n, output logic [31:0] d, output logic [31:0] t,
                           output logic [31:0] b);
        d = '0;
        t = '0;
        b = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            d[i] = dclk;
            t[i] = tick;
            b[i] = busy;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("idle_wait", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_b = 1'b0;
        act   = 1'b0;
        fast  = 1'b0;
`ifdef DCLK_GEN_LOAD_EN
        ld     = 1'b0;
        div_in = '0;
`endif
        // Reset held with clock running, then release with act low.
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {29'b0, dclk, tick, busy}, 32'd0);
        #4 rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_after_rel", {29'b0, dclk, tick, busy}, 32'd0);

        // Slow mode: 4 high, 4 low, tick once per period.
        act = 1'b1;
        capture(16, cap_d, cap_t, cap_b);
        check_eq("slow_dclk", cap_d, 32'h0000_0F0F);
        check_eq("slow_tick", cap_t, 32'h0000_0101);
        check_eq("slow_busy", cap_b, 32'h0000_FFFF);
        act = 1'b0;
        @(posedge clk);
        #1;
        check_eq("stop_at_end", {30'b0, dclk, busy}, 32'd0);

        // Fast mode (H=1): toggles every cycle, tick on every high.
        fast = 1'b1;
        act  = 1'b1;
        capture(8, cap_d, cap_t, cap_b);
        check_eq("fast_dclk", cap_d, 32'h0000_0055);
        check_eq("fast_tick", cap_t, 32'h0000_0055);
        capture(1, cap_d, cap_t, cap_b);
        check_eq("fast_hi", {cap_d[0], cap_t[0]}, 32'd3);
        // Switch to slow during HI: current 2-cycle period finishes, next is 8.
        fast = 1'b0;
        capture(12, cap_d, cap_t, cap_b);
        check_eq("switch_dclk", cap_d, 32'h0000_0E1E);
        check_eq("switch_tick", cap_t, 32'h0000_0202);
        act = 1'b0;
        wait_idle();

        // act dropped in the 2nd HI cycle: full period completes, then idle.
        act = 1'b1;
        capture(2, cap_d, cap_t, cap_b);
        check_eq("drop_start", cap_d, 32'h0000_0003);
        act = 1'b0;
        capture(10, cap_d, cap_t, cap_b);
        check_eq("drop_dclk", cap_d, 32'h0000_0003);
        check_eq("drop_busy", cap_b, 32'h0000_003F);
        check_eq("drop_tick", cap_t, 32'h0000_0000);

        // Asynchronous reset mid-LO, restart one cycle after release.
        act = 1'b1;
        capture(6, cap_d, cap_t, cap_b);
        check_eq("pre_rst_dclk", cap_d, 32'h0000_000F);
        #2 rst_b = 1'b0;
        #1 check_eq("rst_async_lo", {29'b0, dclk, tick, busy}, 32'd0);
        #2 rst_b = 1'b1;
        #1 check_eq("rst_rel_idle", {29'b0, dclk, tick, busy}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("restart_1cyc", {29'b0, dclk, tick, busy}, 32'd7);
        // Asynchronous reset mid-HI must drop dclk without waiting for an edge.
        #2 rst_b = 1'b0;
        #1 check_eq("rst_async_hi", {29'b0, dclk, tick, busy}, 32'd0);
        #2 rst_b = 1'b1;
        capture(8, cap_d, cap_t, cap_b);
        check_eq("post_rst_dclk", cap_d, 32'h0000_000F);
        check_eq("post_rst_tick", cap_t, 32'h0000_0001);
        check_eq("post_rst_busy", cap_b, 32'h0000_00FF);
        act = 1'b0;
        wait_idle();

`ifdef DCLK_GEN_LOAD_EN
        // Runtime load while running slow: current period stays 8, then 4, then div_in=0 gives 2.
        act = 1'b1;
        capture(1, cap_d, cap_t, cap_b);
        ld     = 1'b1;
        div_in = 8'd2;
        capture(13, cap_d, cap_t, cap_b);
        ld = 1'b0;
        check_eq("ld2_dclk", cap_d, 32'h0000_1987);
        ld     = 1'b1;
        div_in = 8'd0;
        capture(1, cap_d, cap_t, cap_b);
        ld = 1'b0;
        check_eq("ld0_first", cap_d, 32'd0);
        capture(5, cap_d, cap_t, cap_b);
        check_eq("ld0_dclk", cap_d, 32'h0000_000A);
        check_eq("ld0_tick", cap_t, 32'h0000_000A);
        act = 1'b0;
        wait_idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
